// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit front-end: control encodings,
// FSM state type, default address map and small decode helpers.
package lsu_pkg;

    // Size/sign encodings carried on the control field
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Default map: ch0 data memory, ch1 input buffer, ch2 output buffer
    localparam int          LSU_N_CH_DEF    = 3;
    localparam logic [95:0] LSU_CH_BASE_DEF = {32'h0000_7800, 32'h0000_7000, 32'h0000_2000};
    localparam logic [95:0] LSU_CH_MASK_DEF = {32'h0000_FFE0, 32'h0000_FFC0, 32'h0000_E000};

    // True for the five defined size/sign encodings
    function automatic logic lsu_control_legal(input logic [2:0] control);
        logic legal;
        case (control)
            LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True when a halfword sits on an odd address or a word is not 4-byte aligned
    function automatic logic lsu_misaligned(input logic [2:0] control, input logic [1:0] offset);
        logic mis;
        case (control)
            LSU_H, LSU_HU: mis = offset[0];
            LSU_W:         mis = |offset;
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero
// extension for loads. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  control,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  bmask,
    output logic [31:0] ld_data
);

    logic [7:0]  rd_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Split the read word into byte lanes for easy offset selection
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = rdata[8*gi +: 8];
    end

    assign byte_sel = rd_byte[offset];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    // Store steering: replicate the datum on every lane, enable only its lanes
    always_comb begin
        wdata = st_data;
        bmask = 4'b1111;
        case (control)
            LSU_B, LSU_BU: begin
                wdata = {4{st_data[7:0]}};
                bmask = 4'b0001 << offset;
            end
            LSU_H, LSU_HU: begin
                wdata = {2{st_data[15:0]}};
                bmask = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = st_data;
                bmask = 4'b1111;
            end
        endcase
    end

    // Load extraction: pick the addressed lane and extend to 32 bits
    always_comb begin
        ld_data = 32'h0;
        case (control)
            LSU_B:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  ld_data = {24'h0, byte_sel};
            LSU_H:   ld_data = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  ld_data = {16'h0, half_sel};
            LSU_W:   ld_data = rdata;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit front-end: valid/ready request intake, address decode to
// N_CH memory-mapped channels, ack wait with bus timeout, and a one-cycle
// registered response. Optional build macro LSU_MISALIGN_TRAP_EN turns
// misaligned halfword/word accesses into error responses; without it the
// address is aligned down and the access proceeds.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int                N_CH    = LSU_N_CH_DEF,
    parameter logic [N_CH*32-1:0] CH_BASE = LSU_CH_BASE_DEF,
    parameter logic [N_CH*32-1:0] CH_MASK = LSU_CH_MASK_DEF,
    parameter int                TIMEOUT = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [31:0]         i_addr,
    input  logic [31:0]         i_st_data,
    input  logic [2:0]          i_control,
    output logic                o_rsp_valid,
    output logic [31:0]         o_rsp_data,
    output logic                o_rsp_err,
    output logic [N_CH-1:0]     o_mem_sel,
    output logic                o_mem_we,
    output logic [31:0]         o_mem_addr,
    output logic [31:0]         o_mem_wdata,
    output logic [3:0]          o_mem_bmask,
    input  logic [N_CH*32-1:0]  i_mem_rdata,
    input  logic [N_CH-1:0]     i_mem_ack
);

    // Counter runs 0..TIMEOUT-1 while waiting; the last value expires the access
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N_CH-1:0]  sel_reg, sel_next;
    logic             we_reg, we_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [3:0]       bmask_reg, bmask_next;
    logic [2:0]       ctrl_reg, ctrl_next;
    logic [1:0]       off_reg, off_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_err_reg, rsp_err_next;
    logic [31:0]      rsp_data_reg, rsp_data_next;

    logic [N_CH-1:0]  hit;
    logic [N_CH-1:0]  sel_dec;
    logic [31:0]      rd_lane [N_CH];
    logic [31:0]      rdata_sel;
    logic             ack_hit;
    logic             misalign;
    logic [1:0]       req_off;
    logic             req_ok;

    logic [2:0]       align_ctrl;
    logic [1:0]       align_off;
    logic [31:0]      align_wdata;
    logic [3:0]       align_bmask;
    logic [31:0]      align_ld;

    // Per-channel address match and per-channel read data gated by the registered select
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign hit[gi]     = (i_addr & CH_MASK[32*gi +: 32]) == CH_BASE[32*gi +: 32];
        assign rd_lane[gi] = sel_reg[gi] ? i_mem_rdata[32*gi +: 32] : 32'h0;
    end

    // Lowest-index match wins: isolate the least significant set bit
    assign sel_dec = hit & (~hit + N_CH'(1));

    // OR-merge the gated lanes; at most one is non-zero
    always_comb begin
        rdata_sel = 32'h0;
        for (int k = 0; k < N_CH; k++) begin
            rdata_sel = rdata_sel | rd_lane[k];
        end
    end

    assign ack_hit = |(i_mem_ack & sel_reg);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned accesses are trapped, so the raw offset is kept
    assign misalign = lsu_misaligned(i_control, i_addr[1:0]);
    assign req_off  = i_addr[1:0];
`else
    // Misaligned accesses are aligned down: H drops bit 0, W drops both bits
    assign misalign = 1'b0;
    always_comb begin
        req_off = i_addr[1:0];
        case (i_control)
            LSU_H, LSU_HU: req_off = {i_addr[1], 1'b0};
            LSU_W:         req_off = 2'b00;
            default:       req_off = i_addr[1:0];
        endcase
    end
`endif

    assign req_ok = lsu_control_legal(i_control) && (|sel_dec) && !misalign;

    // One steering instance: fed by the incoming request in IDLE (store lanes),
    // by the registered request otherwise (load extraction at ack time)
    assign align_ctrl = (state_reg == IDLE) ? i_control : ctrl_reg;
    assign align_off  = (state_reg == IDLE) ? req_off   : off_reg;

    lsu_align u_align (
        .control (align_ctrl),
        .offset  (align_off),
        .st_data (i_st_data),
        .rdata   (rdata_sel),
        .wdata   (align_wdata),
        .bmask   (align_bmask),
        .ld_data (align_ld)
    );

    // Ready is the only combinational output; it is blocked while reset is asserted
    assign o_req_ready = (state_reg == IDLE) && !i_rst;

    // Next-state and next-register logic for the request/access/response FSM
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sel_next       = sel_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        bmask_next     = bmask_reg;
        ctrl_next      = ctrl_reg;
        off_next       = off_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_data_next  = 32'h0;

        case (state_reg)
            IDLE: begin
                if (i_req_valid) begin
                    ctrl_next = i_control;
                    off_next  = req_off;
                    cnt_next  = '0;
                    if (req_ok) begin
                        state_next = ACCESS;
                        sel_next   = sel_dec;
                        we_next    = i_req_we;
                        addr_next  = {i_addr[31:2], 2'b00};
                        wdata_next = i_req_we ? align_wdata : 32'h0;
                        bmask_next = i_req_we ? align_bmask : 4'b1111;
                    end else begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (ack_hit || (cnt_reg == CNT_LAST)) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = !ack_hit;
                    rsp_data_next  = (ack_hit && !we_reg) ? align_ld : 32'h0;
                    cnt_next       = '0;
                    sel_next       = '0;
                    we_next        = 1'b0;
                    addr_next      = 32'h0;
                    wdata_next     = 32'h0;
                    bmask_next     = 4'h0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer silently
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sel_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            bmask_reg     <= 4'h0;
            ctrl_reg      <= 3'b000;
            off_reg       <= 2'b00;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= 32'h0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sel_reg       <= sel_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            bmask_reg     <= bmask_next;
            ctrl_reg      <= ctrl_next;
            off_reg       <= off_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    assign o_mem_sel   = sel_reg;
    assign o_mem_we    = we_reg;
    assign o_mem_addr  = addr_reg;
    assign o_mem_wdata = wdata_reg;
    assign o_mem_bmask = bmask_reg;
    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_err   = rsp_err_reg;
    assign o_rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with the default three-channel map and TIMEOUT=15.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [2:0]  control;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  mem_sel;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic [95:0] mem_rdata;
    logic [2:0]  mem_ack;

    int checks = 0;
    int errors = 0;

    lsu_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_addr      (addr),
        .i_st_data   (st_data),
        .i_control   (control),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_mem_sel   (mem_sel),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_bmask (mem_bmask),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge (edge 0); returns in cycle 1
    task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] c);
        req_valid = 1'b1;
        req_we    = we;
        addr      = a;
        st_data   = d;
        control   = c;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        addr      = 32'h0;
        st_data   = 32'h0;
        control   = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (mem_sel !== 3'b000) begin errors++; $display("FAIL rst_sel got %b exp 000", mem_sel); end
        checks++; if (mem_bmask !== 4'h0) begin errors++; $display("FAIL rst_bmask got %b exp 0000", mem_bmask); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
        $display("reset: done");
    endtask

    task automatic test_store_word();
        start_req(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 3'b010);
        checks++; if (mem_sel !== 3'b001) begin errors++; $display("FAIL sw_sel got %b exp 001", mem_sel); end
        checks++; if (mem_bmask !== 4'b1111) begin errors++; $display("FAIL sw_bmask got %b exp 1111", mem_bmask); end
        checks++; if (mem_addr !== 32'h0000_2004) begin errors++; $display("FAIL sw_addr got %h exp 00002004", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", mem_wdata); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_we got %b exp 1", mem_we); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sw_ready_busy got %b exp 0", req_ready); end
        mem_ack = 3'b001;
        tick();
        mem_ack = 3'b000;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL sw_rsp got v=%b e=%b exp v=1 e=0", rsp_valid, rsp_err); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL sw_rsp_data got %h exp 0", rsp_data); end
        checks++; if (mem_sel !== 3'b000) begin errors++; $display("FAIL sw_sel_release got %b exp 000", mem_sel); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sw_after got v=%b r=%b exp v=0 r=1", rsp_valid, req_ready); end
        $display("store word 0x2004: done");
    endtask

    // Load from ch0 with three wait states; a stray ack on ch1 must be ignored
    task automatic test_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] exp_data,
                             input logic [31:0] exp_addr);
        mem_rdata = {32'hCAFE_BABE, 32'h1234_5678, 32'h80FF_0000};
        start_req(1'b0, a, 32'h0, c);
        checks++; if (mem_sel !== 3'b001 || mem_we !== 1'b0 || mem_bmask !== 4'b1111) begin errors++; $display("FAIL ld_bus got sel=%b we=%b bm=%b exp 001 0 1111", mem_sel, mem_we, mem_bmask); end
        checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL ld_addr got %h exp %h", mem_addr, exp_addr); end
        mem_ack = 3'b010;
        tick();
        mem_ack = 3'b000;
        checks++; if (rsp_valid !== 1'b0 || mem_sel !== 3'b001) begin errors++; $display("FAIL ld_stray_ack got v=%b sel=%b exp v=0 sel=001", rsp_valid, mem_sel); end
        tick();
        tick();
        mem_ack = 3'b001;
        tick();
        mem_ack = 3'b000;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL ld_rsp got v=%b e=%b exp v=1 e=0", rsp_valid, rsp_err); end
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL ld_data ctrl=%b got %h exp %h", c, rsp_data, exp_data); end
        tick();
        $display("load ctrl=%b addr=%h: data %h", c, a, rsp_data);
    endtask

    task automatic test_store_half();
        start_req(1'b1, 32'h0000_7002, 32'h0000_1234, 3'b001);
        checks++; if (mem_sel !== 3'b010) begin errors++; $display("FAIL sh_sel got %b exp 010", mem_sel); end
        checks++; if (mem_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata got %h exp 12341234", mem_wdata); end
        checks++; if (mem_bmask !== 4'b1100) begin errors++; $display("FAIL sh_bmask got %b exp 1100", mem_bmask); end
        checks++; if (mem_addr !== 32'h0000_7000) begin errors++; $display("FAIL sh_addr got %h exp 00007000", mem_addr); end
        mem_ack = 3'b010;
        tick();
        mem_ack = 3'b000;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL sh_rsp got v=%b e=%b exp v=1 e=0", rsp_valid, rsp_err); end
        tick();
        $display("store half 0x7002: done");
    endtask

    task automatic test_store_byte();
        start_req(1'b1, 32'h0000_7801, 32'hFFFF_FFA5, 3'b000);
        checks++; if (mem_sel !== 3'b100) begin errors++; $display("FAIL sb_sel got %b exp 100", mem_sel); end
        checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", mem_wdata); end
        checks++; if (mem_bmask !== 4'b0010) begin errors++; $display("FAIL sb_bmask got %b exp 0010", mem_bmask); end
        mem_ack = 3'b100;
        tick();
        mem_ack = 3'b000;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL sb_rsp got v=%b e=%b exp v=1 e=0", rsp_valid, rsp_err); end
        tick();
        $display("store byte 0x7801: done");
    endtask

    // Requests that must be rejected without touching the bus
    task automatic test_error(input logic we, input logic [31:0] a, input logic [2:0] c);
        start_req(we, a, 32'h5555_AAAA, c);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL err_rsp addr=%h got v=%b e=%b exp v=1 e=1", a, rsp_valid, rsp_err); end
        checks++; if (rsp_data !== 32'h0 || mem_sel !== 3'b000) begin errors++; $display("FAIL err_side addr=%h got d=%h sel=%b exp 0 000", a, rsp_data, mem_sel); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_sel !== 3'b000) begin errors++; $display("FAIL err_after got v=%b r=%b sel=%b exp 0 1 000", rsp_valid, req_ready, mem_sel); end
        $display("error request addr=%h ctrl=%b: done", a, c);
    endtask

    task automatic test_timeout();
        int early;
        int late;
        early = 0;
        start_req(1'b0, 32'h0000_2000, 32'h0, 3'b010);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (rsp_valid !== 1'b0 || mem_sel !== 3'b001) early++;
            tick();
        end
        checks++; if (early != 0) begin errors++; $display("FAIL to_early got %0d bad cycles exp 0", early); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp cycle16 got v=%b e=%b exp v=1 e=1", rsp_valid, rsp_err); end
        tick();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_after got r=%b v=%b exp r=1 v=0", req_ready, rsp_valid); end
        // Retry, then reset in cycle 5 of the access
        start_req(1'b0, 32'h0000_2000, 32'h0, 3'b010);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++; if (mem_sel !== 3'b000 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL to_rst got sel=%b v=%b r=%b exp 000 0 0", mem_sel, rsp_valid, req_ready); end
        rst = 1'b0;
        late = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (rsp_valid !== 1'b0 || mem_sel !== 3'b000) late++;
        end
        checks++; if (late != 0) begin errors++; $display("FAIL to_rst_silent got %0d bad cycles exp 0", late); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL to_rst_ready got %b exp 1", req_ready); end
        $display("timeout and reset-abandon: done");
    endtask

    task automatic test_misalign();
        mem_rdata = {32'hCAFE_BABE, 32'h1234_5678, 32'h1122_3344};
        start_req(1'b0, 32'h0000_2006, 32'h0, 3'b010);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_sel !== 3'b000) begin errors++; $display("FAIL lw_mis got v=%b e=%b sel=%b exp 1 1 000", rsp_valid, rsp_err, mem_sel); end
        tick();
`else
        checks++; if (mem_sel !== 3'b001 || mem_addr !== 32'h0000_2004) begin errors++; $display("FAIL lw_mis_bus got sel=%b a=%h exp 001 00002004", mem_sel, mem_addr); end
        mem_ack = 3'b001;
        tick();
        mem_ack = 3'b000;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h1122_3344) begin errors++; $display("FAIL lw_mis_rsp got v=%b e=%b d=%h exp 1 0 11223344", rsp_valid, rsp_err, rsp_data); end
        tick();
`endif
        $display("load word 0x2006: done");
    endtask

    initial begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        addr      = 32'h0;
        st_data   = 32'h0;
        control   = 3'b000;
        mem_rdata = 96'h0;
        mem_ack   = 3'b000;
        rst       = 1'b1;
        #1;
        test_reset();
        test_store_word();
        test_load(3'b000, 32'h0000_2003, 32'hFFFF_FF80, 32'h0000_2000);
        test_load(3'b100, 32'h0000_2003, 32'h0000_0080, 32'h0000_2000);
        test_load(3'b001, 32'h0000_2002, 32'hFFFF_80FF, 32'h0000_2000);
        test_load(3'b101, 32'h0000_2002, 32'h0000_80FF, 32'h0000_2000);
        test_store_half();
        test_store_byte();
        test_error(1'b0, 32'h0000_5000, 3'b010);
        test_error(1'b1, 32'h0000_2000, 3'b011);
        test_timeout();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
